// File: rtl/inst_mem_responder.sv
// Instruction-memory responder for the IF stage.
// Holds a word-addressed instruction array, models a fixed read latency and
// raises a stall request until the instruction for the presented PC is valid.
// A loader port writes the array at any time; writes to the word currently
// held (or being read this edge) are forwarded so the output stays coherent.
module inst_mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [31:0]           pc_i,
  output logic [31:0]           inst_o,
  output logic                  stallreq_o,
  output logic                  misalign_o,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [31:0]           ld_data_i
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0]           mem_q [0:DEPTH-1];

  logic [31:0]           cur_addr_q, cur_addr_d;
  logic [3:0]            cnt_q,      cnt_d;
  logic                  valid_q,    valid_d;
  logic [31:0]           inst_q,     inst_d;

  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [ADDR_WIDTH-1:0] pc_idx;
  logic [31:0]           rd_cur;
  logic [31:0]           rd_pc;
  logic                  hit;
  logic                  misaligned;
  logic                  new_req;

  // Upper PC bits do not take part in indexing, so addresses wrap mod depth.
  assign cur_idx    = cur_addr_q[ADDR_WIDTH+1:2];
  assign pc_idx     = pc_i[ADDR_WIDTH+1:2];

  // Read ports see a same-edge loader write to the addressed word.
  assign rd_cur     = (ld_we_i && (ld_addr_i == cur_idx)) ? ld_data_i : mem_q[cur_idx];
  assign rd_pc      = (ld_we_i && (ld_addr_i == pc_idx))  ? ld_data_i : mem_q[pc_idx];

  assign hit        = valid_q && (cur_addr_q == pc_i);
  assign misaligned = (pc_i[1:0] != 2'b00);
  // Same address with nothing pending and nothing valid (after idle/reset) also refetches.
  assign new_req    = !hit && ((cur_addr_q != pc_i) || ((cnt_q == 4'd0) && !valid_q));

  assign inst_o     = (ce_i && hit) ? inst_q : 32'h0;
  assign stallreq_o = ce_i && !hit && !misaligned;
  assign misalign_o = ce_i && misaligned;

  // Loader write port; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (ld_we_i) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  // Fetch sequencing: idle, hold on misalign, capture new address, count down wait states.
  always_comb begin
    cur_addr_d = cur_addr_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    inst_d     = inst_q;

    // Keep a held instruction coherent with a loader write to the same word.
    if (valid_q && ld_we_i && (ld_addr_i == cur_idx)) begin
      inst_d = ld_data_i;
    end

    if (!ce_i) begin
      valid_d = 1'b0;
      cnt_d   = 4'd0;
    end else if (!misaligned && new_req) begin
      cur_addr_d = pc_i;
      valid_d    = 1'b0;
      if (WAIT_CYCLES == 0) begin
        valid_d = 1'b1;
        inst_d  = rd_pc;
      end else begin
        cnt_d = 4'(WAIT_CYCLES);
      end
    end else if (!misaligned && (cnt_q != 4'd0) && (cur_addr_q == pc_i)) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        valid_d = 1'b1;
        inst_d  = rd_cur;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q <= 32'h0;
      cnt_q      <= 4'd0;
      valid_q    <= 1'b0;
      inst_q     <= 32'h0;
    end else begin
      cur_addr_q <= cur_addr_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      inst_q     <= inst_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_responder.sv
// Testbench for inst_mem_responder: one instance with two wait states and one
// with zero wait states share the same stimulus. Each stimulus cycle pushes its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_inst_mem_responder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce_i = 1'b0;
  logic [31:0]   pc_i = 32'h0;
  logic          ld_we_i = 1'b0;
  logic [AW-1:0] ld_addr_i = '0;
  logic [31:0]   ld_data_i = 32'h0;

  logic [31:0]   inst2, inst0;
  logic          stall2, stall0, mis2, mis0;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          sel;   // 0: two-wait instance, 1: zero-wait instance
    bit          chk;
    string       tag;
    logic [31:0] inst;
    logic        stall;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];

  inst_mem_responder #(.WAIT_CYCLES(2), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i),
    .inst_o(inst2), .stallreq_o(stall2), .misalign_o(mis2),
    .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
  );

  inst_mem_responder #(.WAIT_CYCLES(0), .ADDR_WIDTH(AW)) dut0 (
    .clk(clk), .rst(rst), .ce_i(ce_i), .pc_i(pc_i),
    .inst_o(inst0), .stallreq_o(stall0), .misalign_o(mis0),
    .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_data_i(ld_data_i)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  // Monitor: compare the outputs presented this cycle against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk) begin
        if (e.sel) begin
          cmp(e.tag, "inst_o",     inst0,         e.inst);
          cmp(e.tag, "stallreq_o", {31'h0, stall0}, {31'h0, e.stall});
          cmp(e.tag, "misalign_o", {31'h0, mis0},   {31'h0, e.mis});
        end else begin
          cmp(e.tag, "inst_o",     inst2,         e.inst);
          cmp(e.tag, "stallreq_o", {31'h0, stall2}, {31'h0, e.stall});
          cmp(e.tag, "misalign_o", {31'h0, mis2},   {31'h0, e.mis});
        end
      end
    end
  end

  task automatic step(input bit sel, input string tag, input logic r, input logic c,
                      input logic [31:0] pc, input logic we, input logic [AW-1:0] a,
                      input logic [31:0] d, input bit chk, input logic [31:0] ei,
                      input logic es, input logic em);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ce_i = c; pc_i = pc; ld_we_i = we; ld_addr_i = a; ld_data_i = d;
    e.sel = sel; e.chk = chk; e.tag = tag; e.inst = ei; e.stall = es; e.mis = em;
    exp_q.push_back(e);
  endtask

  // Aligned fetch cycle on the two-wait instance, no loader write.
  task automatic f2(input string tag, input logic [31:0] pc, input logic [31:0] ei, input logic es);
    step(1'b0, tag, 1'b0, 1'b1, pc, 1'b0, '0, 32'h0, 1'b1, ei, es, 1'b0);
  endtask

  task automatic f0(input string tag, input logic [31:0] pc, input logic [31:0] ei, input logic es);
    step(1'b1, tag, 1'b0, 1'b1, pc, 1'b0, '0, 32'h0, 1'b1, ei, es, 1'b0);
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [31:0] d);
    step(1'b0, "load", 1'b0, 1'b0, 32'h0, 1'b1, a, d, 1'b1, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // T1 reset, memory idle
    step(1'b0, "reset", 1'b1, 1'b0, 32'h6,   1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b0, "reset", 1'b1, 1'b0, 32'h4,   1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, "reset", 1'b1, 1'b0, 32'h103, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);

    load(10'd0,  32'h34011100);
    load(10'd1,  32'h34020020);
    load(10'd2,  32'hAAAA0002);
    load(10'd4,  32'h44440004);
    load(10'd5,  32'h55550005);
    load(10'd16, 32'h11110010);

    // T2 basic fetch with two wait states
    f2("fetch0", 32'h0, 32'h0, 1'b1);
    f2("fetch0", 32'h0, 32'h0, 1'b1);
    f2("fetch0", 32'h0, 32'h0, 1'b1);
    f2("fetch0", 32'h0, 32'h34011100, 1'b0);
    f2("fetch4", 32'h4, 32'h0, 1'b1);
    f2("fetch4", 32'h4, 32'h0, 1'b1);
    f2("fetch4", 32'h4, 32'h0, 1'b1);
    f2("fetch4", 32'h4, 32'h34020020, 1'b0);

    // T3 branch abort: fetch of 0x8 replaced by 0x40 one cycle in
    f2("abort",  32'h8,  32'h0, 1'b1);
    f2("abort",  32'h40, 32'h0, 1'b1);
    f2("abort",  32'h40, 32'h0, 1'b1);
    f2("abort",  32'h40, 32'h0, 1'b1);
    f2("abort",  32'h40, 32'h11110010, 1'b0);

    // T4 misaligned PC holds state; returning to 0x40 hits immediately
    step(1'b0, "misalign", 1'b0, 1'b1, 32'h6, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    f2("misalign_hold", 32'h40, 32'h11110010, 1'b0);

    // T5 coherence with a held instruction
    f2("coh", 32'h10, 32'h0, 1'b1);
    f2("coh", 32'h10, 32'h0, 1'b1);
    f2("coh", 32'h10, 32'h0, 1'b1);
    step(1'b0, "coh_wr", 1'b0, 1'b1, 32'h10, 1'b1, 10'd4, 32'hDEADBEEF, 1'b1, 32'h44440004, 1'b0, 1'b0);
    f2("coh_after", 32'h10, 32'hDEADBEEF, 1'b0);

    // Loader write on the same edge as the final wait-state read
    f2("rdwr", 32'h14, 32'h0, 1'b1);
    f2("rdwr", 32'h14, 32'h0, 1'b1);
    step(1'b0, "rdwr", 1'b0, 1'b1, 32'h14, 1'b1, 10'd5, 32'h0BADF00D, 1'b1, 32'h0, 1'b1, 1'b0);
    f2("rdwr_after", 32'h14, 32'h0BADF00D, 1'b0);

    // Chip enable drop forces a refetch of the same address
    step(1'b0, "idle", 1'b0, 1'b0, 32'h14, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    f2("refetch", 32'h14, 32'h0, 1'b1);
    f2("refetch", 32'h14, 32'h0, 1'b1);
    f2("refetch", 32'h14, 32'h0, 1'b1);
    f2("refetch", 32'h14, 32'h0BADF00D, 1'b0);

    // Reset in the middle of a fetch
    f2("rstmid", 32'h0, 32'h0, 1'b1);
    step(1'b0, "rstmid", 1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    f2("rstmid", 32'h0, 32'h0, 1'b1);
    f2("rstmid", 32'h0, 32'h0, 1'b1);
    f2("rstmid", 32'h0, 32'h0, 1'b1);
    f2("rstmid", 32'h0, 32'h34011100, 1'b0);

    // T6 zero wait states and address wrap
    step(1'b1, "w0_idle", 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    f0("w0_wrap", 32'h1004, 32'h0, 1'b1);
    f0("w0_wrap", 32'h1004, 32'h34020020, 1'b0);
    f0("w0_seq",  32'h0,    32'h0, 1'b1);
    f0("w0_seq",  32'h0,    32'h34011100, 1'b0);
    step(1'b1, "w0_mis", 1'b0, 1'b1, 32'h1, 1'b0, '0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    f0("w0_hold", 32'h0, 32'h34011100, 1'b0);

    step(1'b0, "drain", 1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    cmp("drain", "pending_expectations", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
